// File: rtl/bpsk_pkg.sv
// ============================================================================
// Module : bpsk_pkg
// Brief  : Shared BPSK receiver parameters and the sample type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bpsk_pkg;

    localparam int SAMPLING_FREQ              = 100_000_000;
    localparam int CARRIER_FREQ               = 6_250_000;
    localparam int CARRIER_SAMPLES_PER_PERIOD = 64;
    localparam int SAMPLES_PER_SYMBOL         = 64;
    localparam int DATA_WIDTH                 = 16;

    localparam int STEP        = CARRIER_SAMPLES_PER_PERIOD / (SAMPLING_FREQ / CARRIER_FREQ);
    localparam int ANGLE_WIDTH = $clog2(CARRIER_SAMPLES_PER_PERIOD);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/cosine_lut.sv
// ============================================================================
// Module : cosine_lut
// Brief  : Combinational cosine ROM, 64 angles, Q1.15 amplitude 32767.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cosine_lut
    import bpsk_pkg::*;
#(
    parameter int READ_PORTS = 1
) (
    input  logic [ANGLE_WIDTH-1:0] in  [READ_PORTS],
    output sample_t                out [READ_PORTS]
);

    // First quadrant inclusive of 90 deg; round(cos(2*pi*i/64) * 32767)
    localparam sample_t QUARTER [17] = '{
        16'sd32767, 16'sd32609, 16'sd32137, 16'sd31356, 16'sd30273,
        16'sd28898, 16'sd27245, 16'sd25329, 16'sd23170, 16'sd20787,
        16'sd18204, 16'sd15446, 16'sd12539, 16'sd9512,  16'sd6393,
        16'sd3212,  16'sd0
    };

    function automatic sample_t cos_lookup(input logic [ANGLE_WIDTH-1:0] angle);
        logic [1:0] quad;
        logic [4:0] qi;
        sample_t    mag;
        quad = angle[5:4];
        qi   = quad[0] ? (5'd16 - {1'b0, angle[3:0]}) : {1'b0, angle[3:0]};
        mag  = QUARTER[qi];
        return (quad[0] ^ quad[1]) ? -mag : mag;
    endfunction

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
        assign out[i] = cos_lookup(in[i]);
    end

endmodule

`default_nettype wire

// File: rtl/bpsk_demodulator.sv
// ============================================================================
// Module : bpsk_demodulator
// Brief  : Coherent BPSK back end: LO mixer plus integrate-and-dump slicer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bpsk_demodulator
    import bpsk_pkg::*;
#(
    parameter int INITIAL_PHASE = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t data_in,
    output logic    data_out
);

    localparam int CNT_W  = $clog2(SAMPLES_PER_SYMBOL);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + CNT_W;

    logic [ANGLE_WIDTH-1:0]    r_phase;
    logic signed [PROD_W-1:0]  r_prod;
    logic                      r_prod_valid;
    logic [CNT_W-1:0]          r_count;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_sum;
    logic [ANGLE_WIDTH-1:0]    w_angle [1];
    sample_t                   w_cos   [1];

    assign w_angle[0] = r_phase;

    cosine_lut #(
        .READ_PORTS (1)
    ) u_cosine_lut (
        .in  (w_angle),
        .out (w_cos)
    );

    assign w_sum = r_acc + {{CNT_W{r_prod[PROD_W-1]}}, r_prod};

    // r_prod_valid keeps the reset-value product out of the first symbol
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase      <= ANGLE_WIDTH'(INITIAL_PHASE);
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_count      <= '0;
            r_acc        <= '0;
            data_out     <= 1'b0;
        end else begin
            r_phase      <= r_phase + ANGLE_WIDTH'(STEP);
            r_prod       <= data_in * w_cos[0];
            r_prod_valid <= 1'b1;
            if (r_prod_valid) begin
                if (r_count == CNT_W'(SAMPLES_PER_SYMBOL - 1)) begin
                    r_count  <= '0;
                    r_acc    <= '0;
                    data_out <= !w_sum[ACC_W-1] && (w_sum != '0);
                end else begin
                    r_count  <= r_count + 1'b1;
                    r_acc    <= w_sum;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bpsk_demodulator.sv
// ============================================================================
// Module : tb_bpsk_demodulator
// Brief  : Scoreboard bench: stimulus queues expected bits, monitor checks them.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bpsk_demodulator;
    import bpsk_pkg::*;

    localparam int SPS    = SAMPLES_PER_SYMBOL;
    localparam int N      = CARRIER_SAMPLES_PER_PERIOD;
    localparam int AMP    = 2**(DATA_WIDTH-1) - 1;
    localparam int K_POS  = 0;
    localparam int K_NEG  = 1;
    localparam int K_ZERO = 2;

    logic    clk     = 1'b0;
    logic    rst     = 1'b1;
    sample_t data_in = '0;
    logic    data_out;

    logic [ANGLE_WIDTH-1:0] lut_in  [2];
    sample_t                lut_out [2];

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;
    int n_samp   = 0;
    bit exp_q [$];
    bit last_exp   = 1'b0;
    bit last_valid = 1'b0;

    always #5 clk = ~clk;

    bpsk_demodulator #(
        .INITIAL_PHASE (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out)
    );

    cosine_lut #(
        .READ_PORTS (2)
    ) u_lut (
        .in  (lut_in),
        .out (lut_out)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic int cos_ref(input int angle);
        return int'($cos(2.0 * 3.14159265358979 * angle / N) * AMP);
    endfunction

    task automatic drive_sample(input int kind);
        int v;
        v = cos_ref((n_samp * 4) % N);
        case (kind)
            K_POS:   data_in = sample_t'(v);
            K_NEG:   data_in = sample_t'(-v);
            default: data_in = '0;
        endcase
        n_samp++;
        @(negedge clk);
    endtask

    task automatic send_symbol(input int kind);
        exp_q.push_back(kind == K_POS);
        repeat (SPS) drive_sample(kind);
    endtask

    task automatic send_partial(input int kind, input int count);
        repeat (count) drive_sample(kind);
    endtask

    task automatic tail();
        repeat (8) drive_sample(K_ZERO);
    endtask

    // Called on a falling edge; releases on a falling edge so sample 0 meets edge 1
    task automatic do_reset();
        check_int("queue_drained", exp_q.size(), 0, 0);
        exp_q.delete();
        rst     = 1'b0;
        data_in = '0;
        #1;
        check_bit("reset_out", data_out, 1'b0);
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        n_samp = 0;
    endtask

    always @(posedge clk) begin
        if (!rst) cyc = 0;
        else      cyc = cyc + 1;
    end

    always @(posedge clk) begin
        bit e;
        #1;
        if (!rst) begin
            last_valid = 1'b0;
        end else if (cyc > SPS) begin
            if ((cyc - 1) % SPS == 0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_bit("decision", data_out, e);
                    last_exp   = e;
                    last_valid = 1'b1;
                end else begin
                    last_valid = 1'b0;
                end
            end else if (last_valid && ((cyc % SPS) == 0 || (cyc - 1) % SPS == SPS / 2)) begin
                check_bit("hold", data_out, last_exp);
            end
        end else if (cyc == SPS / 2) begin
            check_bit("pre_first", data_out, 1'b0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        @(negedge clk);

        lut_in[0] = 6'd0;  lut_in[1] = 6'd16; #1;
        check_int("lut_0",  int'(lut_out[0]),  32767, 0);
        check_int("lut_16", int'(lut_out[1]),  0,     0);
        lut_in[0] = 6'd32; lut_in[1] = 6'd48; #1;
        check_int("lut_32", int'(lut_out[0]), -32767, 0);
        check_int("lut_48", int'(lut_out[1]),  0,     0);
        lut_in[0] = 6'd8;  lut_in[1] = 6'd40; #1;
        check_int("lut_8",  int'(lut_out[0]),  23170, 1);
        check_int("lut_40", int'(lut_out[1]), -23170, 1);
        @(negedge clk);

        do_reset();
        repeat (3) send_symbol(K_POS);
        tail();

        do_reset();
        repeat (3) send_symbol(K_NEG);
        tail();

        do_reset();
        for (int i = 0; i < 4; i++) send_symbol((i % 2 == 0) ? K_POS : K_NEG);
        tail();

        do_reset();
        for (int i = 0; i < 1000; i++) begin
            k = int'($urandom_range(0, 1));
            send_symbol(k);
        end
        tail();

        do_reset();
        send_symbol(K_POS);
        send_symbol(K_ZERO);
        send_symbol(K_POS);
        send_symbol(K_ZERO);
        tail();

        // Reset 40 samples into symbol 1: LO sits 180 deg from a fresh start
        do_reset();
        send_symbol(K_POS);
        send_partial(K_POS, 40);
        check_bit("pre_reset_out", data_out, 1'b1);
        rst     = 1'b0;
        data_in = '0;
        #1;
        check_bit("async_clear", data_out, 1'b0);
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        n_samp = 0;
        send_symbol(K_ZERO);
        send_symbol(K_POS);
        tail();

        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

`default_nettype wire
